// File: rtl/toggle_cover_detector_if.sv
// Sample/report bundle between the monitored-signal source and the toggle-cover detector.
// The master drives the sample controls; the slave returns the per-bit pulses and coverage count.
interface toggle_cover_detector_if #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  modport master (
    output enable,
    output clear,
    output sig,
    input  valid,
    input  covered_cnt,
    input  all_covered
  );

  modport slave (
    input  enable,
    input  clear,
    input  sig,
    output valid,
    output covered_cnt,
    output all_covered
  );
endinterface

// File: rtl/toggle_cover_detector.sv
// Per-bit toggle-coverage tracker: pulses valid[i] once when bit i has seen both a rise and a fall,
// and keeps a running count of fully toggled bits since reset or clear.
module toggle_cover_detector #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  toggle_cover_detector_if.slave bus
);

  logic [WIDTH-1:0] prev;
  logic             base_ok;
  logic [WIDTH-1:0] seen_rise;
  logic [WIDTH-1:0] seen_fall;
  logic [WIDTH-1:0] valid_q;
  logic [CNT_W-1:0] covered_cnt_q;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] seen_rise_nxt;
  logic [WIDTH-1:0] seen_fall_nxt;
  logic [WIDTH-1:0] new_cov;
  logic [CNT_W-1:0] new_cnt;

  // Edge detection against the last enabled sample; a bit is new when both flags complete now.
  always_comb begin
    rise          = ~prev & bus.sig;
    fall          = prev & ~bus.sig;
    seen_rise_nxt = seen_rise | rise;
    seen_fall_nxt = seen_fall | fall;
    new_cov       = (seen_rise_nxt & seen_fall_nxt) & ~(seen_rise & seen_fall);
  end

  // Population count of bits completing on this sample.
  always_comb begin
    new_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      new_cnt = new_cnt + CNT_W'(new_cov[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev          <= '0;
      base_ok       <= 1'b0;
      seen_rise     <= '0;
      seen_fall     <= '0;
      valid_q       <= '0;
      covered_cnt_q <= '0;
    end else if (bus.clear) begin
      // prev is left alone: base_ok=0 forces the next enabled sample to be a baseline.
      base_ok       <= 1'b0;
      seen_rise     <= '0;
      seen_fall     <= '0;
      valid_q       <= '0;
      covered_cnt_q <= '0;
    end else if (!bus.enable) begin
      valid_q <= '0;
    end else if (!base_ok) begin
      prev    <= bus.sig;
      base_ok <= 1'b1;
      valid_q <= '0;
    end else begin
      prev          <= bus.sig;
      seen_rise     <= seen_rise_nxt;
      seen_fall     <= seen_fall_nxt;
      valid_q       <= new_cov;
      covered_cnt_q <= covered_cnt_q + new_cnt;
    end
  end

  assign bus.valid       = valid_q;
  assign bus.covered_cnt = covered_cnt_q;
  assign bus.all_covered = (covered_cnt_q == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Scoreboard bench for toggle_cover_detector: the driver queues the expected post-edge outputs,
// a monitor pops one entry per clock and compares it with the DUT.
module tb_toggle_cover_detector;
  localparam int unsigned WIDTH = 27;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL1 = 27'h7FFFFFF;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic [CNT_W-1:0] c;
    logic             a;
    string            tag;
  } exp_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  toggle_cover_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  toggle_cover_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] v,
                       input logic [CNT_W-1:0] c, input logic a);
    n_cmp++;
    if (bus.valid !== v || bus.covered_cnt !== c || bus.all_covered !== a) begin
      n_err++;
      $display("FAIL %s: got valid=%h cnt=%0d all=%b, want valid=%h cnt=%0d all=%b",
               tag, bus.valid, bus.covered_cnt, bus.all_covered, v, c, a);
    end
  endtask

  // Drive one sample and queue the outputs expected right after the following rising edge.
  task automatic step(input logic en, input logic clr, input logic [WIDTH-1:0] s,
                      input logic [WIDTH-1:0] v, input logic [CNT_W-1:0] c,
                      input logic a, input string tag);
    exp_t e;
    @(negedge clock);
    bus.enable = en;
    bus.clear  = clr;
    bus.sig    = s;
    e.v = v; e.c = c; e.a = a; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, e.v, e.c, e.a);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.sig    = '0;
    #1;
    check("reset_t0", '0, '0, 1'b0);

    // Reset held while sig toggles with enable high.
    step(1, 0, ALL1, '0, 0, 0, "rst_hold0");
    step(1, 0, '0,   '0, 0, 0, "rst_hold1");
    step(1, 0, ALL1, '0, 0, 0, "rst_hold2");
    step(1, 0, '0,   '0, 0, 0, "rst_hold3");
    @(negedge clock);
    reset = 1'b1;

    // Bit 0: baseline, rise, fall.
    step(1, 0, 27'h0, '0,    0, 0, "b0_base");
    step(1, 0, 27'h1, '0,    0, 0, "b0_rise");
    step(1, 0, 27'h0, 27'h1, 1, 0, "b0_fall_pulse");
    step(1, 0, 27'h0, '0,    1, 0, "b0_pulse_end");

    // Bits 3 and 5 complete together.
    step(1, 0, 27'h28, '0,     1, 0, "b35_rise");
    step(1, 0, 27'h0,  27'h28, 3, 0, "b35_fall_pulse");
    step(1, 0, 27'h0,  '0,     3, 0, "b35_pulse_end");

    // Covered bit 0 keeps toggling: no new events.
    for (int i = 0; i < 10; i++)
      step(1, 0, (i % 2 == 0) ? 27'h1 : 27'h0, '0, 3, 0, "b0_retoggle");

    // All bits toggle; only the not-yet-covered ones pulse.
    step(1, 0, ALL1,  '0,          3,  0, "all_rise_partial");
    step(1, 0, 27'h0, 27'h7FFFFD6, 27, 1, "all_fall_partial");

    // Fresh epoch: every bit completes on one edge.
    step(0, 1, 27'h0, '0,   0,  0, "clear1");
    step(1, 0, 27'h0, '0,   0,  0, "full_base");
    step(1, 0, ALL1,  '0,   0,  0, "full_rise");
    step(1, 0, 27'h0, ALL1, 27, 1, "full_fall_pulse");
    step(1, 0, 27'h0, '0,   27, 1, "full_hold");

    // Clear on the same edge a toggle would complete; next enabled sample is a baseline.
    step(0, 1, 27'h0, '0,    0, 0, "clear2");
    step(1, 0, 27'h0, '0,    0, 0, "c2_base");
    step(1, 0, 27'h1, '0,    0, 0, "c2_rise");
    step(1, 1, 27'h0, '0,    0, 0, "clear_wins");
    step(1, 0, 27'h1, '0,    0, 0, "post_clear_base");
    step(1, 0, 27'h0, '0,    0, 0, "post_clear_fall");
    step(1, 0, 27'h1, 27'h1, 1, 0, "post_clear_rise_pulse");
    step(1, 0, 27'h1, '0,    1, 0, "post_clear_end");

    // Enable low while sig toggles: nothing changes.
    step(0, 0, 27'h0, '0, 1, 0, "gap0");
    step(0, 0, ALL1,  '0, 1, 0, "gap1");
    step(0, 0, 27'h0, '0, 1, 0, "gap2");
    step(0, 0, ALL1,  '0, 1, 0, "gap3");
    // Compared against last enabled sample (27'h1): rises on bits 1..26 only.
    step(1, 0, ALL1,  '0,          1,  0, "gap_resume_rise");
    step(1, 0, 27'h0, 27'h7FFFFFE, 27, 1, "gap_resume_fall");

    // Async reset while valid is high.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", '0, '0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    bus.enable = 1'b0;

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
        @(posedge clock);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_err++;
        $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
    end
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
